framed_bytes_receiver: RTL and testbench

//  Successor to the fixed-length byte receiver: assembles L bytes of B bits into one word,

---
 rtl/framed_bytes_receiver.sv | 129 ++++++++++++
 tb/tb_framed_bytes_receiver.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/framed_bytes_receiver.sv
// Assembles L bytes of B bits into one word, with optional sync-byte hunting,
// mid-frame resync and an inter-byte timeout. Results are registered and held.
`default_nettype none

module framed_bytes_receiver #(
  parameter int unsigned     B         = 8,
  parameter int unsigned     L         = 4,
  parameter int unsigned     SYNC_EN   = 1,
  parameter logic [B-1:0]    SYNC_BYTE = 8'h24,
  parameter int unsigned     RESYNC    = 0,
  parameter int unsigned     TIMEOUT   = 0
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic             load,
  input  logic [B-1:0]     data,
  output logic             resolve,
  output logic [L*B-1:0]   result,
  output logic             busy,
  output logic [7:0]       count,
  output logic             error
);

  localparam int unsigned LW = L * B;

  localparam logic [0:0] ST_HUNT = 1'b0;
  localparam logic [0:0] ST_RECV = 1'b1;

  localparam bit         SYNC    = (SYNC_EN != 0);
  localparam bit         RESYNC_ON = (RESYNC != 0) && SYNC;
  localparam bit         TMO_ON  = (TIMEOUT != 0);
  localparam logic [0:0] ST_IDLE = SYNC ? ST_HUNT : ST_RECV;
  localparam logic [7:0] LAST    = 8'(L - 1);
  localparam logic [15:0] TMO_M1 = TMO_ON ? 16'(TIMEOUT - 1) : 16'd0;

  logic [0:0]    state_q,   state_d;
  logic [7:0]    count_q,   count_d;
  logic [15:0]   timer_q,   timer_d;
  logic [LW-1:0] shift_q,   shift_d;
  logic [LW-1:0] result_q,  result_d;
  logic          resolve_q, resolve_d;
  logic          error_q,   error_d;

  logic [LW-1:0] shifted;
  logic          is_sync;
  logic          busy_c;
  logic          timer_exp;

  always_comb begin
    shifted   = (shift_q << B) | LW'(data);
    is_sync   = (data == SYNC_BYTE);
    busy_c    = (state_q == ST_RECV) && ((count_q != '0) || SYNC);
    // The timer expires on the idle cycle that would make it reach TIMEOUT
    timer_exp = TMO_ON && busy_c && !load && (timer_q == TMO_M1);

    state_d   = state_q;
    count_d   = count_q;
    timer_d   = timer_q;
    shift_d   = shift_q;
    result_d  = result_q;
    resolve_d = 1'b0;
    error_d   = 1'b0;

    if (start) begin
      state_d = ST_IDLE;
      count_d = '0;
      timer_d = '0;
    end else if (state_q == ST_HUNT) begin
      if (load && is_sync) begin
        state_d = ST_RECV;
        count_d = '0;
        timer_d = '0;
      end
    end else if (load) begin
      timer_d = '0;
      if (RESYNC_ON && is_sync) begin
        count_d = '0;
        error_d = (count_q != '0);
      end else begin
        shift_d = shifted;
        if (count_q == LAST) begin
          result_d  = shifted;
          resolve_d = 1'b1;
          count_d   = '0;
          state_d   = ST_IDLE;
        end else begin
          count_d = count_q + 8'd1;
        end
      end
    end else if (timer_exp) begin
      error_d = 1'b1;
      count_d = '0;
      timer_d = '0;
      state_d = ST_IDLE;
    end else if (busy_c && (timer_q != 16'hFFFF)) begin
      timer_d = timer_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      timer_q   <= '0;
      shift_q   <= '0;
      result_q  <= '0;
      resolve_q <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      timer_q   <= timer_d;
      shift_q   <= shift_d;
      result_q  <= result_d;
      resolve_q <= resolve_d;
      error_q   <= error_d;
    end
  end

  assign resolve = resolve_q;
  assign result  = result_q;
  assign busy    = busy_c;
  assign count   = count_q;
  assign error   = error_q;

endmodule

`default_nettype wire

// File: tb/tb_framed_bytes_receiver.sv
// Four receiver configurations share one input stream; a byte-list model of each
// is compared against its DUT on every cycle, plus directed literal checks.
module tb_framed_bytes_receiver;

  logic       clock = 1'b0;
  logic       reset_n, start, load;
  logic [7:0] data;

  always #5 clock = ~clock;

  // Instance configurations: L, SYNC_EN, RESYNC, TIMEOUT
  localparam int CL [4] = '{4, 4, 4, 1};
  localparam int CS [4] = '{0, 1, 1, 0};
  localparam int CR [4] = '{0, 0, 1, 0};
  localparam int CT [4] = '{0, 0, 5, 0};

  logic        rs [4];
  logic        er [4];
  logic        bz [4];
  logic [7:0]  ct [4];
  logic [31:0] rr0, rr1, rr2;
  logic [7:0]  rr3;

  framed_bytes_receiver #(.B(8), .L(4), .SYNC_EN(0), .SYNC_BYTE(8'h24), .RESYNC(0), .TIMEOUT(0)) u0 (
    .clock(clock), .reset_n(reset_n), .start(start), .load(load), .data(data),
    .resolve(rs[0]), .result(rr0), .busy(bz[0]), .count(ct[0]), .error(er[0]));
  framed_bytes_receiver #(.B(8), .L(4), .SYNC_EN(1), .SYNC_BYTE(8'h24), .RESYNC(0), .TIMEOUT(0)) u1 (
    .clock(clock), .reset_n(reset_n), .start(start), .load(load), .data(data),
    .resolve(rs[1]), .result(rr1), .busy(bz[1]), .count(ct[1]), .error(er[1]));
  framed_bytes_receiver #(.B(8), .L(4), .SYNC_EN(1), .SYNC_BYTE(8'h24), .RESYNC(1), .TIMEOUT(5)) u2 (
    .clock(clock), .reset_n(reset_n), .start(start), .load(load), .data(data),
    .resolve(rs[2]), .result(rr2), .busy(bz[2]), .count(ct[2]), .error(er[2]));
  framed_bytes_receiver #(.B(8), .L(1), .SYNC_EN(0), .SYNC_BYTE(8'h24), .RESYNC(0), .TIMEOUT(0)) u3 (
    .clock(clock), .reset_n(reset_n), .start(start), .load(load), .data(data),
    .resolve(rs[3]), .result(rr3), .busy(bz[3]), .count(ct[3]), .error(er[3]));

  int total = 0;
  int bad   = 0;
  bit armed = 1'b0;

  // Model state: hunting flag, list of bytes in the open frame, idle-cycle count
  bit          hunting [4];
  logic [7:0]  fb      [4][4];
  int          fn      [4];
  int          idle    [4];
  logic [31:0] m_res   [4];
  bit          m_rsv   [4];
  bit          m_err   [4];

  function automatic void chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", n, act, exp);
    end
  endfunction

  function automatic bit m_busy(input int k);
    return !hunting[k] && (fn[k] > 0 || CS[k] != 0);
  endfunction

  function automatic logic [31:0] dut_res(input int k);
    case (k)
      0:       return rr0;
      1:       return rr1;
      2:       return rr2;
      default: return {24'd0, rr3};
    endcase
  endfunction

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      bit was_busy;
      was_busy = m_busy(k);
      m_rsv[k] = 1'b0;
      m_err[k] = 1'b0;
      if (!reset_n) begin
        hunting[k] = (CS[k] != 0);
        fn[k] = 0;
        idle[k] = 0;
        m_res[k] = 32'd0;
      end else if (start) begin
        hunting[k] = (CS[k] != 0);
        fn[k] = 0;
        idle[k] = 0;
      end else if (hunting[k]) begin
        if (load && data == 8'h24) begin
          hunting[k] = 1'b0;
          fn[k] = 0;
          idle[k] = 0;
        end
      end else if (load) begin
        idle[k] = 0;
        if (CR[k] != 0 && CS[k] != 0 && data == 8'h24) begin
          m_err[k] = (fn[k] > 0);
          fn[k] = 0;
        end else begin
          fb[k][fn[k]] = data;
          fn[k]++;
          if (fn[k] == CL[k]) begin
            logic [31:0] w;
            w = 32'd0;
            for (int i = 0; i < CL[k]; i++) w = (w << 8) | {24'd0, fb[k][i]};
            m_res[k] = w;
            m_rsv[k] = 1'b1;
            fn[k] = 0;
            hunting[k] = (CS[k] != 0);
          end
        end
      end else if (was_busy && CT[k] > 0) begin
        idle[k]++;
        if (idle[k] == CT[k]) begin
          m_err[k] = 1'b1;
          fn[k] = 0;
          idle[k] = 0;
          hunting[k] = (CS[k] != 0);
        end
      end
    end
    if (!reset_n) armed = 1'b1;
  endtask

  // Drive one cycle of inputs; returns 1 time unit after the sampling edge
  task automatic cyc(input logic l, input logic [7:0] d, input logic s = 1'b0, input logic rn = 1'b1);
    load = l;
    data = d;
    start = s;
    reset_n = rn;
    @(posedge clock);
    model_step();
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    cyc(1'b1, d);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00);
  endtask

  always @(negedge clock) begin
    if (armed) begin
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("resolve[%0d]", k), {31'd0, rs[k]}, {31'd0, m_rsv[k]});
        chk($sformatf("error[%0d]", k),   {31'd0, er[k]}, {31'd0, m_err[k]});
        chk($sformatf("busy[%0d]", k),    {31'd0, bz[k]}, {31'd0, m_busy(k)});
        chk($sformatf("count[%0d]", k),   {24'd0, ct[k]}, 32'(fn[k]));
        chk($sformatf("result[%0d]", k),  dut_res(k),     m_res[k]);
      end
    end
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; load = 1'b0; data = 8'h00;
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("rst_result2", rr2, 32'd0);
    chk("rst_busy2", {31'd0, bz[2]}, 32'd0);
    chk("rst_count2", {24'd0, ct[2]}, 32'd0);
    cyc(1'b0, 8'h00);

    // T1 / T6 first frame: plain 4-byte frame and single-byte frames
    send(8'h12); send(8'h34); send(8'h56); send(8'h78);
    chk("t1_resolve", {31'd0, rs[0]}, 32'd1);
    chk("t1_result", rr0, 32'h12345678);
    chk("t1_l1_result", {24'd0, rr3}, 32'h78);
    idle_n(1);
    chk("t1_resolve_pulse", {31'd0, rs[0]}, 32'd0);

    // T2: sync hunting
    send(8'h41); send(8'h24); send(8'h01); send(8'h02); send(8'h03); send(8'h04);
    chk("t2_result", rr1, 32'h01020304);
    send(8'h05); send(8'h06);
    chk("t2_hold", rr1, 32'h01020304);
    chk("t2_busy", {31'd0, bz[1]}, 32'd0);
    cyc(1'b0, 8'h00, 1'b1);

    // T3: timeout aborts a stalled frame
    send(8'h24); send(8'h0A); send(8'h0B);
    idle_n(4);
    chk("t3_no_err_early", {31'd0, er[2]}, 32'd0);
    idle_n(1);
    chk("t3_err", {31'd0, er[2]}, 32'd1);
    chk("t3_busy", {31'd0, bz[2]}, 32'd0);
    chk("t3_count", {24'd0, ct[2]}, 32'd0);
    send(8'h24); send(8'h01);
    chk("t3_sync_as_data", rr1, 32'h0A0B2401);
    send(8'h02); send(8'h03); send(8'h04);
    chk("t3_resolve", {31'd0, rs[2]}, 32'd1);
    chk("t3_result", rr2, 32'h01020304);
    cyc(1'b0, 8'h00, 1'b1);

    // T4: resync mid-frame
    send(8'h24); send(8'hAA); send(8'hBB); send(8'h24);
    chk("t4_err", {31'd0, er[2]}, 32'd1);
    chk("t4_count", {24'd0, ct[2]}, 32'd0);
    send(8'h01);
    chk("t4_norsync", rr1, 32'hAABB2401);
    send(8'h02); send(8'h03); send(8'h04);
    chk("t4_result", rr2, 32'h01020304);
    cyc(1'b0, 8'h00, 1'b1);

    // T5: start with the third byte, then reset mid-frame
    send(8'h24); send(8'hD1); send(8'hD2);
    cyc(1'b1, 8'hD3, 1'b1);
    chk("t5_no_resolve", {31'd0, rs[2]}, 32'd0);
    chk("t5_count", {24'd0, ct[2]}, 32'd0);
    send(8'h24); send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
    chk("t5_result", rr2, 32'hC1C2C3C4);
    send(8'h24); send(8'hE1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_rst_result", rr2, 32'd0);
    chk("t5_rst_count", {24'd0, ct[2]}, 32'd0);
    chk("t5_rst_busy", {31'd0, bz[2]}, 32'd0);
    cyc(1'b0, 8'h00);

    // T6: back-to-back single-byte frames
    send(8'h7F);
    chk("t6_first", {24'd0, rr3}, 32'h7F);
    send(8'h80);
    chk("t6_second", {24'd0, rr3}, 32'h80);
    chk("t6_resolve", {31'd0, rs[3]}, 32'd1);

    // Randomized traffic: sync bytes, idle streaks, sporadic start and reset
    for (int n = 0; n < 4000; n++) begin
      int r;
      logic [7:0] d;
      r = $urandom_range(0, 199);
      d = ($urandom_range(0, 9) < 3) ? 8'h24 : 8'($urandom);
      cyc(($urandom_range(0, 9) < 6), d, (r < 3), (r != 199));
    end

    @(negedge clock);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
